toggle_event_decoder: RTL and testbench

Receive-side decoder for toggle-encoded event lines driven by a toggle flip-flop (each event flips the line once). It synchronizes the incoming toggle line into the local clock domain and emits a one-cycle pulse per detected toggle. It also batches toggle counts into a single-entry output register drained over a valid/ready handshake. It sits between a remote toggle-encoding source and local consumers that need either per-event pulses or accumulated counts.

---
 rtl/toggle_dec_pkg.sv | 18 +
 rtl/toggle_event_decoder_if.sv | 24 ++
 rtl/toggle_sync.sv | 33 +++
 rtl/toggle_event_decoder.sv | 115 +++++++++++
 tb/tb_toggle_event_decoder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_dec_pkg.sv
// Shared types and constants for the toggle event decoder and the
// toggle-based CDC blocks built on the same synchronizer.
package toggle_dec_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } dec_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;

    // Largest value representable in an unsigned counter of the given width.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/toggle_event_decoder_if.sv
// Batch output channel of the toggle event decoder: valid/ready with a
// saturating count and an overflow flag.
interface toggle_event_decoder_if #(
    parameter int CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output out_valid,
        output out_count,
        output out_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        input  out_ovf,
        output out_ready
    );
endinterface

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for a level that is asynchronous to clk; all
// stages clear to 0 on reset.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] s_reg;
    logic [SYNC_STAGES-1:0] s_next;

    assign s_next[0] = d;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            assign s_next[gi] = s_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_reg <= '0;
        end else begin
            s_reg <= s_next;
        end
    end

    assign q = s_reg[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns a toggle-encoded event line into per-event pulses and into
// saturating event-count batches drained over a valid/ready channel.
module toggle_event_decoder
    import toggle_dec_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   t_in,
    output logic                   evt_pulse,
    output logic                   t_level,
    toggle_event_decoder_if.master out_if
);

    localparam int               PCW        = $clog2(SYNC_STAGES + 1);
    localparam logic [PCW-1:0]   PRIME_LAST = PCW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(cnt_max(CNT_W));

    dec_state_t       state_reg, state_next;
    logic [PCW-1:0]   prime_cnt_reg, prime_cnt_next;
    logic             sync_q;
    logic             prev_reg;
    logic             evt;
    logic             run_evt;
    logic             evt_pulse_reg;
    logic [CNT_W-1:0] accum_reg, accum_next;
    logic             acc_ovf_reg, acc_ovf_next;
    logic             out_valid_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_ovf_reg;
    logic             load;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (sync_q)
    );

    assign evt = sync_q ^ prev_reg;

    // PRIME lasts SYNC_STAGES+1 cycles so a nonzero line level present at
    // reset release has fully propagated through prev_reg before counting.
    always_comb begin
        state_next     = state_reg;
        prime_cnt_next = prime_cnt_reg;
        run_evt        = 1'b0;
        case (state_reg)
            PRIME: begin
                if (prime_cnt_reg == PRIME_LAST) begin
                    state_next = RUN;
                end else begin
                    prime_cnt_next = prime_cnt_reg + PCW'(1);
                end
            end
            RUN:     run_evt = evt;
            default: state_next = PRIME;
        endcase
    end

    // A saturated accumulator drops further events and flags the batch.
    always_comb begin
        accum_next   = accum_reg;
        acc_ovf_next = acc_ovf_reg;
        if (run_evt) begin
            if (accum_reg == CNT_MAX) begin
                acc_ovf_next = 1'b1;
            end else begin
                accum_next = accum_reg + CNT_W'(1);
            end
        end
        load = (accum_next != '0) && (!out_valid_reg || out_if.out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= PRIME;
            prime_cnt_reg <= '0;
            prev_reg      <= 1'b0;
            evt_pulse_reg <= 1'b0;
            accum_reg     <= '0;
            acc_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prime_cnt_reg <= prime_cnt_next;
            prev_reg      <= sync_q;
            evt_pulse_reg <= run_evt;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_count_reg <= accum_next;
                out_ovf_reg   <= acc_ovf_next;
                accum_reg     <= '0;
                acc_ovf_reg   <= 1'b0;
            end else begin
                accum_reg   <= accum_next;
                acc_ovf_reg <= acc_ovf_next;
                if (out_valid_reg && out_if.out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign evt_pulse        = evt_pulse_reg;
    assign t_level          = sync_q;
    assign out_if.out_valid = out_valid_reg;
    assign out_if.out_count = out_count_reg;
    assign out_if.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder: pulses, batching, backpressure,
// saturation and mid-batch reset.
module tb_toggle_event_decoder;

    logic clk;
    logic reset;
    logic t_in;
    logic evt_pulse;
    logic t_level;

    toggle_event_decoder_if #(.CNT_W(8)) bus ();

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_in      (t_in),
        .evt_pulse (evt_pulse),
        .t_level   (t_level),
        .out_if    (bus.master)
    );

    int   total;
    int   bad;
    int   pulse_cnt;
    int   batch_cnt;
    int   batch_sum;
    int   last_count;
    logic last_ovf;
    int   base_pulse;
    int   base_batch;
    int   base_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after posedge, so values seen at negedge are the
    // ones the DUT samples at the following posedge.
    always @(negedge clk) begin
        if (reset) begin
            if (evt_pulse) pulse_cnt <= pulse_cnt + 1;
            if (bus.out_valid && bus.out_ready) begin
                batch_cnt  <= batch_cnt + 1;
                batch_sum  <= batch_sum + int'(bus.out_count);
                last_count <= int'(bus.out_count);
                last_ovf   <= bus.out_ovf;
                $display("batch %0d: count=%0d ovf=%0d", batch_cnt + 1, bus.out_count, bus.out_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snapshot();
        base_pulse = pulse_cnt;
        base_batch = batch_cnt;
        base_sum   = batch_sum;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        t_in = 1'b1;
        bus.out_ready = 1'b1;
        ticks(3);
        total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL rst_evt_pulse got=%0b exp=0", evt_pulse); end
        total++; if (t_level !== 1'b0) begin bad++; $display("FAIL rst_t_level got=%0b exp=0", t_level); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        total++; if (bus.out_count !== 8'd0) begin bad++; $display("FAIL rst_out_count got=%0d exp=0", bus.out_count); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%0b exp=0", bus.out_ovf); end
        reset = 1'b1;
        snapshot();
        ticks(10);
        total++; if (pulse_cnt - base_pulse != 0) begin bad++; $display("FAIL prime_pulses got=%0d exp=0", pulse_cnt - base_pulse); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL prime_out_valid got=%0b exp=0", bus.out_valid); end
        total++; if (t_level !== 1'b1) begin bad++; $display("FAIL prime_t_level got=%0b exp=1", t_level); end
        t_in = 1'b0;
        ticks(5);
        total++; if (pulse_cnt - base_pulse != 1) begin bad++; $display("FAIL fall_pulses got=%0d exp=1", pulse_cnt - base_pulse); end
        total++; if (batch_cnt - base_batch != 1) begin bad++; $display("FAIL fall_batches got=%0d exp=1", batch_cnt - base_batch); end
        total++; if (last_count != 1) begin bad++; $display("FAIL fall_count got=%0d exp=1", last_count); end
    endtask

    task automatic test_pulse_stream();
        bus.out_ready = 1'b1;
        snapshot();
        t_in = ~t_in;
        ticks(2);
        total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL lat_early_pulse got=%0b exp=0", evt_pulse); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%0b exp=0", bus.out_valid); end
        tick();
        total++; if (evt_pulse !== 1'b1) begin bad++; $display("FAIL lat_pulse got=%0b exp=1", evt_pulse); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0b exp=1", bus.out_valid); end
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", bus.out_count); end
        tick();
        total++; if (evt_pulse !== 1'b0) begin bad++; $display("FAIL lat_pulse_width got=%0b exp=0", evt_pulse); end
        for (int i = 0; i < 15; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(4);
        total++; if (pulse_cnt - base_pulse != 16) begin bad++; $display("FAIL stream_pulses got=%0d exp=16", pulse_cnt - base_pulse); end
        total++; if (batch_cnt - base_batch != 16) begin bad++; $display("FAIL stream_batches got=%0d exp=16", batch_cnt - base_batch); end
        total++; if (batch_sum - base_sum != 16) begin bad++; $display("FAIL stream_sum got=%0d exp=16", batch_sum - base_sum); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        snapshot();
        t_in = ~t_in;
        ticks(4);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%0b exp=1", bus.out_valid); end
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL bp_first_count got=%0d exp=1", bus.out_count); end
        for (int i = 0; i < 9; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(4);
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL bp_stable_count got=%0d exp=1", bus.out_count); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_stable_valid got=%0b exp=1", bus.out_valid); end
        total++; if (batch_cnt - base_batch != 0) begin bad++; $display("FAIL bp_no_accept got=%0d exp=0", batch_cnt - base_batch); end
        total++; if (pulse_cnt - base_pulse != 10) begin bad++; $display("FAIL bp_pulses got=%0d exp=10", pulse_cnt - base_pulse); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_count !== 8'd9) begin bad++; $display("FAIL bp_second_count got=%0d exp=9", bus.out_count); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%0b exp=1", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained_valid got=%0b exp=0", bus.out_valid); end
        total++; if (batch_cnt - base_batch != 2) begin bad++; $display("FAIL bp_batches got=%0d exp=2", batch_cnt - base_batch); end
        total++; if (batch_sum - base_sum != 10) begin bad++; $display("FAIL bp_sum got=%0d exp=10", batch_sum - base_sum); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        snapshot();
        for (int i = 0; i < 8; i++) begin
            t_in = ~t_in;
            tick();
        end
        ticks(4);
        total++; if (pulse_cnt - base_pulse != 8) begin bad++; $display("FAIL b2b_pulses got=%0d exp=8", pulse_cnt - base_pulse); end
        total++; if (batch_cnt - base_batch != 8) begin bad++; $display("FAIL b2b_batches got=%0d exp=8", batch_cnt - base_batch); end
        total++; if (batch_sum - base_sum != 8) begin bad++; $display("FAIL b2b_sum got=%0d exp=8", batch_sum - base_sum); end
        snapshot();
        for (int i = 0; i < 20; i++) begin
            bus.out_ready = ((i % 3) != 2);
            t_in = ~t_in;
            tick();
        end
        bus.out_ready = 1'b1;
        ticks(6);
        total++; if (pulse_cnt - base_pulse != 20) begin bad++; $display("FAIL coin_pulses got=%0d exp=20", pulse_cnt - base_pulse); end
        total++; if (batch_sum - base_sum != 20) begin bad++; $display("FAIL coin_sum got=%0d exp=20", batch_sum - base_sum); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL coin_drained got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        snapshot();
        for (int i = 0; i < 300; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(4);
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL ovf_first_count got=%0d exp=1", bus.out_count); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_first_flag got=%0b exp=0", bus.out_ovf); end
        total++; if (pulse_cnt - base_pulse != 300) begin bad++; $display("FAIL ovf_pulses got=%0d exp=300", pulse_cnt - base_pulse); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_count !== 8'd255) begin bad++; $display("FAIL ovf_sat_count got=%0d exp=255", bus.out_count); end
        total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sat_flag got=%0b exp=1", bus.out_ovf); end
        ticks(3);
        total++; if (batch_cnt - base_batch != 2) begin bad++; $display("FAIL ovf_batches got=%0d exp=2", batch_cnt - base_batch); end
        total++; if (last_ovf !== 1'b1) begin bad++; $display("FAIL ovf_accepted_flag got=%0b exp=1", last_ovf); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b exp=0", bus.out_valid); end
        t_in = ~t_in;
        ticks(4);
        total++; if (last_count != 1) begin bad++; $display("FAIL ovf_after_count got=%0d exp=1", last_count); end
        total++; if (last_ovf !== 1'b0) begin bad++; $display("FAIL ovf_after_flag got=%0b exp=0", last_ovf); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t_in = ~t_in;
            ticks(2);
        end
        ticks(3);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0b exp=1", bus.out_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%0b exp=0", bus.out_valid); end
        total++; if (bus.out_count !== 8'd0) begin bad++; $display("FAIL mid_async_count got=%0d exp=0", bus.out_count); end
        total++; if (t_level !== 1'b0) begin bad++; $display("FAIL mid_async_level got=%0b exp=0", t_level); end
        ticks(3);
        reset = 1'b1;
        snapshot();
        ticks(8);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_prime_valid got=%0b exp=0", bus.out_valid); end
        total++; if (pulse_cnt - base_pulse != 0) begin bad++; $display("FAIL mid_prime_pulses got=%0d exp=0", pulse_cnt - base_pulse); end
        bus.out_ready = 1'b1;
        t_in = ~t_in;
        ticks(4);
        total++; if (batch_cnt - base_batch != 1) begin bad++; $display("FAIL mid_restart_batches got=%0d exp=1", batch_cnt - base_batch); end
        total++; if (last_count != 1) begin bad++; $display("FAIL mid_restart_count got=%0d exp=1", last_count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        pulse_cnt = 0;
        batch_cnt = 0;
        batch_sum = 0;
        last_count = 0;
        last_ovf = 1'b0;
        reset = 1'b0;
        t_in = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_pulse_stream();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
